// File: rtl/flip_flop_d.sv
// D-type register with synchronous active-high reset, parameterised width and an
// optional cascade of STAGES registers (e.g. an input synchronizer chain).
module flip_flop_d #(
    parameter int WIDTH     = 1,
    parameter int STAGES    = 1,
    parameter     RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn
);

    // Reset value fitted to the data width: wider values truncate, narrower zero-extend.
    localparam logic [WIDTH-1:0] RESET_W = WIDTH'($unsigned(RESET_VAL));

    if (WIDTH < 1) begin : g_bad_width
        $error("flip_flop_d: WIDTH must be >= 1 (got %0d)", WIDTH);
    end
    if (STAGES < 1) begin : g_bad_stages
        $error("flip_flop_d: STAGES must be >= 1 (got %0d)", STAGES);
    end

    logic [WIDTH-1:0] stage_d [STAGES];
    logic [WIDTH-1:0] stage_q [STAGES] = '{default: RESET_W};

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            assign stage_d[gi] = D;
        end else begin : g_chain
            assign stage_d[gi] = stage_q[gi-1];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < STAGES; i++) begin
            if (reset) begin
                stage_q[i] <= RESET_W;
            end else begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign Q  = stage_q[STAGES-1];
    assign Qn = ~Q;

endmodule

// File: tb/tb_flip_flop_d.sv
// Randomised bench for flip_flop_d: three configurations driven in lockstep and
// compared against a reset-window history model before and after every rising edge.
module tb_flip_flop_d;

    logic       clk = 1'b0;
    logic       reset;
    logic       d1, d3;
    logic [7:0] d8;
    logic       q1, qn1, q3, qn3;
    logic [7:0] q8, qn8;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-edge history of what was applied at each rising edge.
    logic       rst_h [0:1023];
    logic       d1_h  [0:1023];
    logic [7:0] d8_h  [0:1023];
    logic       d3_h  [0:1023];
    int         n_edges = 0;

    always #5 clk = ~clk;

    flip_flop_d u_ff1 (
        .clk(clk), .reset(reset), .D(d1), .Q(q1), .Qn(qn1)
    );

    flip_flop_d #(.WIDTH(8), .STAGES(1), .RESET_VAL(8'hA5)) u_ff8 (
        .clk(clk), .reset(reset), .D(d8), .Q(q8), .Qn(qn8)
    );

    flip_flop_d #(.WIDTH(1), .STAGES(3), .RESET_VAL(0)) u_ff3 (
        .clk(clk), .reset(reset), .D(d3), .Q(q3), .Qn(qn3)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s edge=%0d got=%h expected=%h", tag, n_edges, got, exp);
        end
    endtask

    // Q after the latest edge: if any of the last `stages` edges had reset, the
    // reset value; otherwise D from (stages-1) edges ago. Before any edge the
    // register holds its initial (reset) value.
    function automatic logic [7:0] exp_q(input int stages, input logic [7:0] rv, input int which);
        int e;
        for (int i = 0; i < stages; i++) begin
            e = n_edges - 1 - i;
            if (e < 0) return rv;
            if (rst_h[e]) return rv;
        end
        e = n_edges - stages;
        case (which)
            0:       return {7'b0, d1_h[e]};
            1:       return d8_h[e];
            default: return {7'b0, d3_h[e]};
        endcase
    endfunction

    task automatic check_all(input string when);
        logic [7:0] e1, e8, e3;
        e1 = exp_q(1, 8'h00, 0);
        e8 = exp_q(1, 8'hA5, 1);
        e3 = exp_q(3, 8'h00, 2);
        chk({when, "_q1"},  {7'b0, q1},  e1);
        chk({when, "_qn1"}, {7'b0, qn1}, {7'b0, ~e1[0]});
        chk({when, "_q8"},  q8,          e8);
        chk({when, "_qn8"}, qn8,         ~e8);
        chk({when, "_q3"},  {7'b0, q3},  e3);
        chk({when, "_qn3"}, {7'b0, qn3}, {7'b0, ~e3[0]});
    endtask

    // One clock: drive on the falling edge, check 1 ns before and 1 ns after the rising edge.
    task automatic step(input logic r, input logic v1, input logic [7:0] v8, input logic v3,
                        input bit glitch);
        @(negedge clk);
        reset = r;
        d1    = v1;
        d8    = v8;
        d3    = v3;
        if (glitch) begin
            #1 reset = 1'b1;
            #2 reset = r;
            #1;
        end else begin
            #4;
        end
        if (n_edges > 0) check_all("pre");
        @(posedge clk);
        rst_h[n_edges] = r;
        d1_h[n_edges]  = v1;
        d8_h[n_edges]  = v8;
        d3_h[n_edges]  = v3;
        n_edges++;
        #1 check_all("post");
    endtask

    initial begin
        reset = 1'b1;
        d1    = 1'b0;
        d8    = 8'h00;
        d3    = 1'b0;

        // Reset held for 10 edges with random data: Q pinned to the reset value.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'($urandom), 8'($urandom), 1'($urandom), 1'b0);
            chk("rst_hold_q1", {7'b0, q1}, 8'h00);
            chk("rst_hold_q8", q8, 8'hA5);
        end

        // Free-running random data.
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'($urandom), 8'($urandom), 1'($urandom), 1'b0);
        end

        // Single-edge reset while D=1 clears Q, next edge recaptures.
        step(1'b0, 1'b1, 8'h11, 1'b0, 1'b0);
        chk("set_q1", {7'b0, q1}, 8'h01);
        step(1'b1, 1'b1, 8'h22, 1'b0, 1'b0);
        chk("one_rst_q1", {7'b0, q1}, 8'h00);
        step(1'b0, 1'b1, 8'h33, 1'b0, 1'b0);
        chk("recap_q1", {7'b0, q1}, 8'h01);

        // Reset pulses that fall entirely between rising edges must be ignored.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'($urandom), 8'($urandom), 1'($urandom), 1'b1);
        end
        step(1'b0, 1'b1, 8'h44, 1'b0, 1'b1);
        chk("glitch_q1", {7'b0, q1}, 8'h01);
        chk("glitch_q8", q8, 8'h44);

        // Wide register with non-zero reset value.
        step(1'b1, 1'b0, 8'h3C, 1'b0, 1'b0);
        chk("w8_rst", q8, 8'hA5);
        step(1'b0, 1'b0, 8'h3C, 1'b0, 1'b0);
        chk("w8_load", q8, 8'h3C);

        // Three-stage chain: single-cycle pulse emerges two edges after capture.
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("s3_cap", {7'b0, q3}, 8'h00);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("s3_mid", {7'b0, q3}, 8'h00);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("s3_out", {7'b0, q3}, 8'h01);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("s3_fall", {7'b0, q3}, 8'h00);
        // Reset while the pulse is in flight discards it.
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("s3_flush", {7'b0, q3}, 8'h00);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("s3_flush2", {7'b0, q3}, 8'h00);

        // Long random run with occasional resets.
        for (int i = 0; i < 200; i++) begin
            step(1'($urandom_range(7) == 0), 1'($urandom), 8'($urandom), 1'($urandom),
                 1'($urandom_range(5) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
